flight_frame_builder: RTL

//  Parametrised successor of the flight-data frame writer. On each frame strobe it snapshots the
//  I2C and GPS words and writes a telemetry frame into a ping-pong RAM: header, frame counter,
//  I2C, GPS, a sub-frame-selected MSRP block, pad and serial number. The readout side always

---
 rtl/flight_frame_builder_if.sv | 31 +++
 rtl/flight_frame_builder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/flight_frame_builder_if.sv
// Bus bundle for flight_frame_builder: frame trigger, sensor snapshots, MSRP read port
// and readout port. slave = builder side, master = environment side.
interface flight_frame_builder_if #(
    parameter int DW        = 16,
    parameter int I2C_WORDS = 10,
    parameter int GPS_WORDS = 14,
    parameter int MSRP_AW   = 8,
    parameter int RAM_AW    = 7
);
    logic                    frame;
    logic [3:0]              frame_cnt;
    logic [I2C_WORDS*DW-1:0] i2c_data;
    logic [GPS_WORDS*DW-1:0] gps_data;
    logic [MSRP_AW-1:0]      rd_msrp;
    logic [DW-1:0]           msrp_data;
    logic [31:0]             serial_number;
    logic [RAM_AW-1:0]       rd_addr;
    logic [DW-1:0]           rd_data;
    logic                    busy;
    logic                    frame_done;
    logic                    overrun;

    modport slave (
        input  frame, frame_cnt, i2c_data, gps_data, msrp_data, serial_number, rd_addr,
        output rd_msrp, rd_data, busy, frame_done, overrun
    );
    modport master (
        output frame, frame_cnt, i2c_data, gps_data, msrp_data, serial_number, rd_addr,
        input  rd_msrp, rd_data, busy, frame_done, overrun
    );
endinterface

// File: rtl/flight_frame_builder.sv
// Telemetry frame builder writing into a ping-pong RAM; readout always sees the last committed bank.
// Optional macro FRAME_CRC_EN appends a CRC-16/CCITT-FALSE word after the serial number.
module flight_frame_builder #(
    parameter int            DW         = 16,
    parameter int            I2C_WORDS  = 10,
    parameter int            GPS_WORDS  = 14,
    parameter int            MSRP_WORDS = 64,
    parameter int            MSRP_AW    = 8,
    parameter int            MSRP_LAT   = 2,
    parameter int            PAD_WORDS  = 4,
    parameter int            RAM_AW     = 7,
    parameter logic [DW-1:0] HEADER     = DW'(16'hFF7F)
) (
    input logic clock,
    input logic reset,
    flight_frame_builder_if.slave bus
);
`ifdef FRAME_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif
    localparam int FRAME_LEN = 2 + I2C_WORDS + GPS_WORDS + MSRP_WORDS + PAD_WORDS + 2 + CRC_WORDS;
    localparam int WC_W = $clog2(I2C_WORDS + GPS_WORDS + MSRP_WORDS + MSRP_LAT + PAD_WORDS + 1);
    localparam logic [RAM_AW:0] LEN_CMP = (RAM_AW+1)'(FRAME_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_CNT, S_I2C, S_GPS, S_MSRP, S_PAD, S_SER_HI, S_SER_LO,
`ifdef FRAME_CRC_EN
        S_CRC,
`endif
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    frame_q, frame_d;
    logic [WC_W-1:0]         wc_q, wc_d;
    logic [RAM_AW-1:0]       wr_addr_q, wr_addr_d;
    logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [DW-1:0]           cnt_q, cnt_d;
    logic [I2C_WORDS*DW-1:0] i2c_q, i2c_d;
    logic [GPS_WORDS*DW-1:0] gps_q, gps_d;
    logic [MSRP_AW-1:0]      rd_msrp_q, rd_msrp_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;
    logic                    busy_q, busy_d, frame_done_q, frame_done_d, overrun_q, overrun_d;
    logic                    start, we;
    logic [DW-1:0]           wdata;
    logic [31:0]             msrp_base;
    logic [DW-1:0]           ram [0:2**(RAM_AW+1)-1];
`ifdef FRAME_CRC_EN
    logic [15:0]             crc_q, crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] w);
        logic [15:0] r;
        r = c;
        for (int i = DW-1; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ w[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction
`endif

    assign start     = bus.frame & ~frame_q;
    assign msrp_base = 32'(bus.frame_cnt[3:2]) * 32'(MSRP_WORDS);

    always_comb begin
        state_d      = state_q;
        frame_d      = bus.frame;
        wc_d         = wc_q;
        wr_addr_d    = wr_addr_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        cnt_d        = cnt_q;
        i2c_d        = i2c_q;
        gps_d        = gps_q;
        rd_msrp_d    = rd_msrp_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = start && (state_q != S_IDLE);
        we           = 1'b0;
        wdata        = '0;
`ifdef FRAME_CRC_EN
        crc_d        = crc_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                i2c_d     = bus.i2c_data;
                gps_d     = bus.gps_data;
                rd_msrp_d = msrp_base[MSRP_AW-1:0];
                wr_addr_d = '0;
                busy_d    = 1'b1;
                state_d   = S_HDR;
`ifdef FRAME_CRC_EN
                crc_d     = 16'hFFFF;
`endif
            end
            S_HDR: begin
                we = 1'b1; wdata = HEADER; state_d = S_CNT;
            end
            S_CNT: begin
                we = 1'b1; wdata = cnt_q; cnt_d = cnt_q + 1'b1;
                wc_d = '0; state_d = S_I2C;
            end
            S_I2C: begin
                we = 1'b1; wdata = i2c_q[DW-1:0]; i2c_d = i2c_q >> DW;
                if (wc_q == WC_W'(I2C_WORDS-1)) begin wc_d = '0; state_d = S_GPS; end
                else wc_d = wc_q + 1'b1;
            end
            S_GPS: begin
                we = 1'b1; wdata = gps_q[DW-1:0]; gps_d = gps_q >> DW;
                if (wc_q == WC_W'(GPS_WORDS-1)) begin wc_d = '0; state_d = S_MSRP; end
                else wc_d = wc_q + 1'b1;
            end
            S_MSRP: begin
                // address issue leads the write stream by the RAM latency
                if (wc_q < WC_W'(MSRP_WORDS)) rd_msrp_d = rd_msrp_q + 1'b1;
                if (wc_q >= WC_W'(MSRP_LAT)) begin we = 1'b1; wdata = bus.msrp_data; end
                if (wc_q == WC_W'(MSRP_WORDS+MSRP_LAT-1)) begin wc_d = '0; state_d = S_PAD; end
                else wc_d = wc_q + 1'b1;
            end
            S_PAD: begin
                we = 1'b1;
                if (wc_q == WC_W'(PAD_WORDS-1)) begin wc_d = '0; state_d = S_SER_HI; end
                else wc_d = wc_q + 1'b1;
            end
            S_SER_HI: begin
                we = 1'b1; wdata = DW'(bus.serial_number[31:16]); state_d = S_SER_LO;
            end
            S_SER_LO: begin
                we = 1'b1; wdata = DW'(bus.serial_number[15:0]);
`ifdef FRAME_CRC_EN
                state_d = S_CRC;
`else
                state_d = S_DONE;
`endif
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                we = 1'b1; wdata = DW'(crc_q); state_d = S_DONE;
            end
`endif
            S_DONE: begin
                rd_bank_d    = wr_bank_q;
                wr_bank_d    = ~wr_bank_q;
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (we) wr_addr_d = wr_addr_q + 1'b1;
`ifdef FRAME_CRC_EN
        if (we && state_q != S_CRC) crc_d = crc_step(crc_q, wdata);
`endif
        rd_data_d = '0;
        if ({1'b0, bus.rd_addr} < LEN_CMP) rd_data_d = ram[{rd_bank_q, bus.rd_addr}];
    end

    always_ff @(posedge clock) begin
        if (we) ram[{wr_bank_q, wr_addr_q}] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            frame_q      <= 1'b0;
            wc_q         <= '0;
            wr_addr_q    <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            cnt_q        <= '0;
            i2c_q        <= '0;
            gps_q        <= '0;
            rd_msrp_q    <= '0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FRAME_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            wc_q         <= wc_d;
            wr_addr_q    <= wr_addr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            cnt_q        <= cnt_d;
            i2c_q        <= i2c_d;
            gps_q        <= gps_d;
            rd_msrp_q    <= rd_msrp_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef FRAME_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign bus.rd_msrp    = rd_msrp_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule
